// File: rtl/tdc_test_pkg.sv
// Shared types and defaults for the TDC self-test sequencer.
// Reset constants are in 25 MHz clk cycles.
package tdc_test_pkg;

    localparam int unsigned CNT_W_DEF = 20;
    localparam int unsigned NP_W_DEF  = 8;

    localparam int unsigned SETTLE_RST = 800000;
    localparam int unsigned GAP_RST    = 400;
    localparam int unsigned PERIOD_RST = 1000;
    localparam int unsigned NP_RST     = 1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        PULSE_GAP,
        PULSE_HOLD,
        FINISH
    } state_e;

endpackage

// File: rtl/tdc_test_timer.sv
// Loadable down-counter; tc_o is high while the count is zero.
// A load value of N makes tc_o visible N edges after the loading edge.
module tdc_test_timer
    import tdc_test_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/tdc_test_sequencer.sv
// Sequences UC-commanded teststart/teststop pulse pairs into the TDC after a
// settle delay; abortable, all outputs registered.
module tdc_test_sequencer #(
    parameter int unsigned CNT_W      = tdc_test_pkg::CNT_W_DEF,
    parameter int unsigned NP_W       = tdc_test_pkg::NP_W_DEF,
    parameter int unsigned SETTLE_RST = tdc_test_pkg::SETTLE_RST,
    parameter int unsigned GAP_RST    = tdc_test_pkg::GAP_RST,
    parameter int unsigned PERIOD_RST = tdc_test_pkg::PERIOD_RST,
    parameter int unsigned NP_RST     = tdc_test_pkg::NP_RST
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cfg_we_i,
    input  logic [CNT_W-1:0] cfg_settle_i,
    input  logic [CNT_W-1:0] cfg_gap_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic [NP_W-1:0]  cfg_npairs_i,
    input  logic             go_i,
    input  logic             abort_i,
    output logic             teststart_o,
    output logic             teststop_o,
    output logic             testing_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic             cfg_err_o,
    output logic [NP_W-1:0]  pairs_done_o
);

    import tdc_test_pkg::*;

    state_e state_q, state_d;

    // UC-visible config registers
    logic [CNT_W-1:0] settle_q, gap_q, period_q;
    logic [NP_W-1:0]  npairs_q;

    // Snapshot of the config validated at go acceptance
    logic [CNT_W-1:0] run_gap_q, run_gap_d, run_period_q, run_period_d;
    logic [NP_W-1:0]  run_np_q, run_np_d;

    logic            teststart_q, teststart_d;
    logic            teststop_q, teststop_d;
    logic            testing_q, testing_d;
    logic            busy_q;
    logic            done_q, done_d;
    logic            aborted_q, aborted_d;
    logic            cfg_err_q, cfg_err_d;
    logic [NP_W-1:0] pairs_q, pairs_d;
    logic [NP_W-1:0] pairs_inc;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_tc;

    logic cfg_ok;

    tdc_test_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    assign pairs_inc = pairs_q + NP_W'(1);
    assign cfg_ok    = (gap_q != '0) && (npairs_q != '0) && (period_q > gap_q);

    always_comb begin
        state_d      = state_q;
        run_gap_d    = run_gap_q;
        run_period_d = run_period_q;
        run_np_d     = run_np_q;
        teststart_d  = 1'b0;
        teststop_d   = 1'b0;
        testing_d    = testing_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        cfg_err_d    = 1'b0;
        pairs_d      = pairs_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;

        unique case (state_q)
            IDLE: begin
                if (go_i) begin
                    if (!cfg_ok) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        testing_d    = 1'b1;
                        pairs_d      = '0;
                        run_gap_d    = gap_q;
                        run_period_d = period_q;
                        run_np_d     = npairs_q;
                        tmr_load     = 1'b1;
                        // Zero settle fires the first start on the accepting edge
                        if (settle_q == '0) begin
                            teststart_d = 1'b1;
                            state_d     = PULSE_GAP;
                            tmr_val     = gap_q - CNT_W'(1);
                        end else begin
                            state_d = SETTLE;
                            tmr_val = settle_q - CNT_W'(1);
                        end
                    end
                end
            end
            SETTLE, PULSE_HOLD: begin
                if (tmr_tc) begin
                    teststart_d = 1'b1;
                    state_d     = PULSE_GAP;
                    tmr_load    = 1'b1;
                    tmr_val     = run_gap_q - CNT_W'(1);
                end
            end
            PULSE_GAP: begin
                if (tmr_tc) begin
                    teststop_d = 1'b1;
                    pairs_d    = pairs_inc;
                    tmr_load   = 1'b1;
                    if (pairs_inc == run_np_q) begin
                        state_d = FINISH;
                        tmr_val = CNT_W'(1);
                    end else begin
                        // Remaining distance to the next start: period - gap edges
                        state_d = PULSE_HOLD;
                        tmr_val = run_period_q - run_gap_q - CNT_W'(1);
                    end
                end
            end
            FINISH: begin
                // One done cycle with busy still high, then back to IDLE
                if (!tmr_tc) begin
                    done_d    = 1'b1;
                    testing_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && abort_i) begin
            state_d     = IDLE;
            teststart_d = 1'b0;
            teststop_d  = 1'b0;
            testing_d   = 1'b0;
            done_d      = 1'b0;
            aborted_d   = 1'b1;
            pairs_d     = pairs_q;
            tmr_load    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            settle_q     <= CNT_W'(SETTLE_RST);
            gap_q        <= CNT_W'(GAP_RST);
            period_q     <= CNT_W'(PERIOD_RST);
            npairs_q     <= NP_W'(NP_RST);
            run_gap_q    <= '0;
            run_period_q <= '0;
            run_np_q     <= '0;
            teststart_q  <= 1'b0;
            teststop_q   <= 1'b0;
            testing_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
            pairs_q      <= '0;
        end else begin
            state_q      <= state_d;
            run_gap_q    <= run_gap_d;
            run_period_q <= run_period_d;
            run_np_q     <= run_np_d;
            teststart_q  <= teststart_d;
            teststop_q   <= teststop_d;
            testing_q    <= testing_d;
            busy_q       <= (state_d != IDLE);
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            cfg_err_q    <= cfg_err_d;
            pairs_q      <= pairs_d;
            if (cfg_we_i && state_q == IDLE) begin
                settle_q <= cfg_settle_i;
                gap_q    <= cfg_gap_i;
                period_q <= cfg_period_i;
                npairs_q <= cfg_npairs_i;
            end
        end
    end

    assign teststart_o  = teststart_q;
    assign teststop_o   = teststop_q;
    assign testing_o    = testing_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign aborted_o    = aborted_q;
    assign cfg_err_o    = cfg_err_q;
    assign pairs_done_o = pairs_q;

endmodule

// File: tb/tb_tdc_test_sequencer.sv
// Directed bench for tdc_test_sequencer; settle default shortened to 200 cycles
// so the default-config run stays short.
module tb_tdc_test_sequencer;

    localparam int CNT_W     = 20;
    localparam int NP_W      = 8;
    localparam int TB_SETTLE = 200;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_we = 1'b0;
    logic [CNT_W-1:0] cfg_settle = '0;
    logic [CNT_W-1:0] cfg_gap = '0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [NP_W-1:0]  cfg_npairs = '0;
    logic             go = 1'b0;
    logic             abort = 1'b0;
    logic             teststart, teststop, testing, busy, done, aborted, cfg_err;
    logic [NP_W-1:0]  pairs_done;
    logic [6:0]       obs;
    logic [6:0]       exp_v;

    int tests = 0;
    int fails = 0;

    always #20 clk = ~clk;

    assign obs = {teststart, teststop, testing, busy, done, aborted, cfg_err};

    tdc_test_sequencer #(
        .CNT_W      (CNT_W),
        .NP_W       (NP_W),
        .SETTLE_RST (TB_SETTLE),
        .GAP_RST    (400),
        .PERIOD_RST (1000),
        .NP_RST     (1)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .cfg_we_i     (cfg_we),
        .cfg_settle_i (cfg_settle),
        .cfg_gap_i    (cfg_gap),
        .cfg_period_i (cfg_period),
        .cfg_npairs_i (cfg_npairs),
        .go_i         (go),
        .abort_i      (abort),
        .teststart_o  (teststart),
        .teststop_o   (teststop),
        .testing_o    (testing),
        .busy_o       (busy),
        .done_o       (done),
        .aborted_o    (aborted),
        .cfg_err_o    (cfg_err),
        .pairs_done_o (pairs_done)
    );

    task automatic load_cfg(input int s, input int g, input int p, input int n);
        @(negedge clk);
        cfg_settle = CNT_W'(s);
        cfg_gap    = CNT_W'(g);
        cfg_period = CNT_W'(p);
        cfg_npairs = NP_W'(n);
        cfg_we     = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Afterwards, the next negedge lies in cycle 1 after the accepting edge
    task automatic pulse_go();
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs got %b exp %b", obs, 7'b0);
        end
        tests++;
        if (pairs_done !== '0) begin
            fails++;
            $display("FAIL reset_pairs got %0d exp 0", pairs_done);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL idle_after_reset got %b exp %b", obs, 7'b0);
        end
    endtask

    // Default config; cfg_we and a second go mid-run must not disturb it
    task automatic test_default_blocked_cfg();
        pulse_go();
        for (int k = 1; k <= 605; k++) begin
            @(negedge clk);
            exp_v = {k == 201, k == 601, k <= 601, k <= 602, k == 602, 1'b0, 1'b0};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL default_run k=%0d got %b exp %b", k, obs, exp_v);
            end
            if (k == 600 || k == 601 || k == 605) begin
                tests++;
                if (pairs_done !== NP_W'(k >= 601 ? 1 : 0)) begin
                    fails++;
                    $display("FAIL default_pairs k=%0d got %0d", k, pairs_done);
                end
            end
            if (k == 50) begin
                cfg_settle = CNT_W'(0);
                cfg_gap    = CNT_W'(1);
                cfg_period = CNT_W'(2);
                cfg_npairs = NP_W'(3);
            end
            cfg_we = (k == 50);
            go     = (k == 60);
        end
    endtask

    // Defaults still in force: start at TB_SETTLE+1, then abort
    task automatic test_no_reload();
        pulse_go();
        for (int k = 1; k <= 204; k++) begin
            @(negedge clk);
            exp_v = {k == 201, 1'b0, k <= 202, k <= 202, 1'b0, k == 203, 1'b0};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL no_reload k=%0d got %b exp %b", k, obs, exp_v);
            end
            abort = (k == 202);
        end
    endtask

    task automatic test_three_pairs();
        int exp_pd;
        load_cfg(0, 1, 2, 3);
        pulse_go();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp_v = {k == 1 || k == 3 || k == 5, k == 2 || k == 4 || k == 6,
                     k <= 6, k <= 7, k == 7, 1'b0, 1'b0};
            exp_pd = (k >= 6) ? 3 : (k >= 4) ? 2 : (k >= 2) ? 1 : 0;
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL three_pairs k=%0d got %b exp %b", k, obs, exp_v);
            end
            tests++;
            if (pairs_done !== NP_W'(exp_pd)) begin
                fails++;
                $display("FAIL three_pairs_cnt k=%0d got %0d exp %0d", k, pairs_done, exp_pd);
            end
        end
    endtask

    task automatic test_invalid_cfg();
        int gv[3] = '{5, 2, 0};
        int pv[3] = '{5, 4, 3};
        int nv[3] = '{1, 0, 1};
        for (int c = 0; c < 3; c++) begin
            load_cfg(3, gv[c], pv[c], nv[c]);
            pulse_go();
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                exp_v = {6'b0, k == 1};
                tests++;
                if (obs !== exp_v) begin
                    fails++;
                    $display("FAIL invalid_cfg c=%0d k=%0d got %b exp %b", c, k, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_abort();
        load_cfg(10, 4, 20, 4);
        pulse_go();
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            exp_v = {k == 11 || k == 31, k == 15, k <= 34, k <= 34, 1'b0, k == 35, 1'b0};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL abort_run k=%0d got %b exp %b", k, obs, exp_v);
            end
            abort = (k == 34);
        end
        tests++;
        if (pairs_done !== NP_W'(1)) begin
            fails++;
            $display("FAIL abort_pairs got %0d exp 1", pairs_done);
        end
    endtask

    task automatic test_idle_abort_go();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL idle_abort got %b exp %b", obs, 7'b0);
        end
        load_cfg(2, 1, 2, 1);
        @(negedge clk);
        go    = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        abort = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            exp_v = {k == 3, k == 4, k <= 4, k <= 5, k == 5, 1'b0, 1'b0};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL go_abort_same k=%0d got %b exp %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        load_cfg(0, 1, 10, 5);
        pulse_go();
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k <= 4) exp_v = {k == 1, k == 2, 1'b1, 1'b1, 3'b0};
            else        exp_v = 7'b0;
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL reset_mid k=%0d got %b exp %b", k, obs, exp_v);
            end
            if (k == 3 || k == 5) begin
                tests++;
                if (pairs_done !== NP_W'(k == 3 ? 1 : 0)) begin
                    fails++;
                    $display("FAIL reset_mid_pairs k=%0d got %0d", k, pairs_done);
                end
            end
            reset = (k == 4);
        end
    endtask

    initial begin
        test_reset();
        test_default_blocked_cfg();
        test_no_reload();
        test_three_pairs();
        test_invalid_cfg();
        test_abort();
        test_idle_abort_go();
        test_reset_mid();
        test_no_reload();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
